// File: rtl/usr_shift_ctrl_pkg.sv
// Shared constants and types for the universal shift register command sequencer.
// The mode encodings match those of the downstream universal shift register.
package usr_pkg;

   localparam int USR_WIDTH = 8;
   localparam int USR_CNT_W = 4;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } usr_state_e;

   typedef struct packed {
      logic [USR_WIDTH-1:0] data;
      logic                 dir;
      logic [USR_CNT_W-1:0] count;
      logic                 fill;
   } usr_cmd_t;

endpackage

// File: rtl/usr_shift_ctrl_fifo.sv
// Two-entry command FIFO for usr_shift_ctrl; only built when USR_SHIFT_CTRL_QUEUE_EN is defined.
// The head entry stays until popped, and the entry behind it is exposed for back-to-back starts.
`ifdef USR_SHIFT_CTRL_QUEUE_EN
module usr_cmd_fifo #(
   parameter int W = 14
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic [W-1:0] next_o,
   output logic [1:0]   count_o,
   output logic         ready_o
);

   logic [W-1:0] mem_q [2];
   logic         rd_q;
   logic [1:0]   cnt_q;
   logic [1:0]   cnt_d;
   logic         ready_q;
   logic         wr_ptr;

   assign wr_ptr = (cnt_q == 2'd0) ? rd_q : ~rd_q;

   always_comb begin
      cnt_d = cnt_q;
      case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_q     <= 1'b0;
         cnt_q    <= 2'd0;
         ready_q  <= 1'b0;
      end else begin
         if (push_i) mem_q[wr_ptr] <= push_data_i;
         if (pop_i)  rd_q <= ~rd_q;
         cnt_q   <= cnt_d;
         ready_q <= (cnt_d != 2'd2);
      end
   end

   assign head_o  = mem_q[rd_q];
   assign next_o  = mem_q[~rd_q];
   assign count_o = cnt_q;
   assign ready_o = ready_q;

endmodule
`endif

// File: rtl/usr_shift_ctrl.sv
// Command sequencer driving mode/datain of the universal shift register: load, shift N, park.
// Define USR_SHIFT_CTRL_QUEUE_EN to put a 2-entry command FIFO in front of the FSM.
//
// state | meaning
// IDLE  | waiting for a command, mode HOLD
// LOAD  | one cycle of parallel load of the captured byte
// SHIFT | count cycles of SHR/SHL with the fill bit on datain
// DONE  | one-cycle done pulse, mode HOLD; may start the next command
module usr_shift_ctrl
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             cmd_fill,
   output logic [1:0]       mode,
   output logic [WIDTH-1:0] datain,
   output logic             busy,
   output logic             done
);

   localparam int CW = WIDTH + CNT_W + 2;
   localparam logic [1:0] ST_IDLE  = S_IDLE;
   localparam logic [1:0] ST_LOAD  = S_LOAD;
   localparam logic [1:0] ST_SHIFT = S_SHIFT;
   localparam logic [1:0] ST_DONE  = S_DONE;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cap_q, cap_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] datain_q, datain_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             start;
   logic [CW-1:0]    src;
   logic [CW-1:0]    cmd_vec;

   // packed command layout: {data, dir, count, fill}
   assign cmd_vec = {cmd_data, cmd_dir, cmd_count, cmd_fill};

`ifdef USR_SHIFT_CTRL_QUEUE_EN
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_ready;
   logic [CW-1:0] fifo_head;
   logic [CW-1:0] fifo_next;
   logic [1:0]    fifo_cnt;

   assign fifo_push = cmd_valid & fifo_ready;
   assign cmd_ready = fifo_ready;

   usr_cmd_fifo #(.W(CW)) u_fifo (
      .clk_i       (clk),
      .rst_n_i     (reset),
      .push_i      (fifo_push),
      .push_data_i (cmd_vec),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .next_o      (fifo_next),
      .count_o     (fifo_cnt),
      .ready_o     (fifo_ready)
   );

   // The running command stays at the FIFO head until its DONE cycle pops it.
   always_comb begin
      start    = 1'b0;
      src      = fifo_head;
      fifo_pop = 1'b0;
      if (state_q == ST_IDLE) begin
         start = (fifo_cnt != 2'd0);
      end else if (state_q == ST_DONE) begin
         fifo_pop = 1'b1;
         start    = (fifo_cnt == 2'd2);
         src      = fifo_next;
      end
   end
`else
   logic ready_q;
   logic ready_d;

   assign start     = cmd_valid & ready_q;
   assign src       = cmd_vec;
   assign cmd_ready = ready_q;
   assign ready_d   = (state_d == ST_IDLE) || (state_d == ST_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ready_q <= 1'b0;
      else        ready_q <= ready_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               cap_d   = src;
               rem_d   = src[CNT_W:1];
            end
         end
         ST_LOAD: state_d = (rem_q == '0) ? ST_DONE : ST_SHIFT;
         ST_SHIFT: begin
            rem_d = rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
            if (start) begin
               state_d = ST_LOAD;
               cap_d   = src;
               rem_d   = src[CNT_W:1];
            end
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      mode_d   = MODE_HOLD;
      datain_d = datain_q;
      case (state_d)
         ST_LOAD: begin
            mode_d   = MODE_LOAD;
            datain_d = cap_d[CW-1:CNT_W+2];
         end
         ST_SHIFT: begin
            mode_d   = cap_d[CNT_W+1] ? MODE_SHL : MODE_SHR;
            datain_d = {WIDTH{cap_d[0]}};
         end
         default: mode_d = MODE_HOLD;
      endcase
      busy_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cap_q    <= '0;
         rem_q    <= '0;
         mode_q   <= MODE_HOLD;
         datain_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cap_q    <= cap_d;
         rem_q    <= rem_d;
         mode_q   <= mode_d;
         datain_q <= datain_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign mode   = mode_q;
   assign datain = datain_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Scoreboard bench for usr_shift_ctrl driving a behavioural universal shift register.
// Queue-mode checks are compiled when USR_SHIFT_CTRL_QUEUE_EN is defined.
module tb_usr_shift_ctrl;
   import usr_pkg::*;

   typedef struct {
      logic [1:0] mode;
      logic       done;
      logic       chk_data;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b1;
   logic       cmd_ready;
   logic [7:0] cmd_data = '0;
   logic       cmd_dir = 1'b0;
   logic [3:0] cmd_count = '0;
   logic       cmd_fill = 1'b0;
   logic [1:0] mode;
   logic [7:0] datain;
   logic       busy;
   logic       done;
   logic [7:0] sr_q = '0;

   exp_t       exp_q[$];
   logic [7:0] fin_q[$];
   int         done_cyc_q[$];
   int         done_seen[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   usr_shift_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_dir   (cmd_dir),
      .cmd_count (cmd_count),
      .cmd_fill  (cmd_fill),
      .mode      (mode),
      .datain    (datain),
      .busy      (busy),
      .done      (done)
   );

   // downstream universal shift register
   always @(posedge clk) begin
      case (mode)
         2'b01:   sr_q <= {datain[7], sr_q[7:1]};
         2'b10:   sr_q <= {sr_q[6:0], datain[0]};
         2'b11:   sr_q <= datain;
         default: sr_q <= sr_q;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] final_value(input usr_cmd_t c);
      logic [7:0] ones = 8'hFF;
      int n = int'(c.count);
      if (c.dir) return (c.data << n) | (c.fill ? ~(ones << n) : 8'h00);
      else       return (c.data >> n) | (c.fill ? ~(ones >> n) : 8'h00);
   endfunction

   function automatic void push_expect(input usr_cmd_t c, input int cyc_now);
      exp_t e;
      e = '{mode: 2'b11, done: 1'b0, chk_data: 1'b1, data: c.data};
      exp_q.push_back(e);
      for (int i = 0; i < int'(c.count); i++) begin
         e = '{mode: (c.dir ? 2'b10 : 2'b01), done: 1'b0, chk_data: 1'b1, data: {8{c.fill}}};
         exp_q.push_back(e);
      end
      e = '{mode: 2'b00, done: 1'b1, chk_data: 1'b0, data: 8'h00};
      exp_q.push_back(e);
      fin_q.push_back(final_value(c));
      done_cyc_q.push_back(cyc_now + 2 + int'(c.count));
   endfunction

   task automatic send_cmd(input usr_cmd_t c, output int stall);
      @(negedge clk);
      cmd_data  = c.data;
      cmd_dir   = c.dir;
      cmd_count = c.count;
      cmd_fill  = c.fill;
      cmd_valid = 1'b1;
      stall     = 0;
      while (!cmd_ready && stall < 200) begin
         @(negedge clk);
         stall++;
      end
      if (!cmd_ready) begin
         chk("accept_timeout", 32'(stall), 32'(0));
         cmd_valid = 1'b0;
      end else begin
         push_expect(c, cyc);
         @(posedge clk);
         #1 cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk("drain_left", 32'(exp_q.size()), 32'(0));
   endtask

   // monitor: every active output cycle is popped against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && (busy || done || mode != 2'b00)) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", {28'h0, mode, busy, done}, 32'h0);
            end else begin
               e = exp_q.pop_front();
               chk("mode", 32'(mode), 32'(e.mode));
               chk("done", 32'(done), 32'(e.done));
               chk("busy", 32'(busy), 32'(!e.done));
               if (e.chk_data) chk("datain", 32'(datain), 32'(e.data));
               if (done) begin
                  done_seen.push_back(cyc);
                  if (fin_q.size() != 0) chk("final_reg", 32'(sr_q), 32'(fin_q.pop_front()));
`ifndef USR_SHIFT_CTRL_QUEUE_EN
                  if (done_cyc_q.size() != 0) chk("done_latency", 32'(cyc), 32'(done_cyc_q.pop_front()));
`endif
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      usr_cmd_t c;
      int st, st_a, st_b, st_c;

      repeat (3) begin
         @(negedge clk);
         chk("rst_mode", 32'(mode), 32'(0));
         chk("rst_ready", 32'(cmd_ready), 32'(0));
         chk("rst_busy", 32'(busy), 32'(0));
         chk("rst_done", 32'(done), 32'(0));
      end
      reset = 1'b1;
      cmd_valid = 1'b0;
      #1 chk("ready_before_edge", 32'(cmd_ready), 32'(0));
      @(negedge clk);
      chk("ready_after_release", 32'(cmd_ready), 32'(1));

      c = '{data: 8'd12, dir: 1'b0, count: 4'd0, fill: 1'b0};
      send_cmd(c, st);
      wait_drain();
      chk("t2_reg", 32'(sr_q), 32'h0C);

      c = '{data: 8'h0C, dir: 1'b0, count: 4'd2, fill: 1'b0};
      send_cmd(c, st);
      wait_drain();
      chk("t3_reg", 32'(sr_q), 32'h03);

      c = '{data: 8'd14, dir: 1'b1, count: 4'd3, fill: 1'b1};
      send_cmd(c, st);
      wait_drain();
      chk("t4_reg", 32'(sr_q), 32'h77);

      c = '{data: 8'hA5, dir: 1'b0, count: 4'd15, fill: 1'b1};
      send_cmd(c, st);
      wait_drain();
      chk("max_count_reg", 32'(sr_q), 32'hFF);

      for (int n = 0; n < 30; n++) begin
         c.data  = 8'($urandom);
         c.dir   = 1'($urandom_range(0, 1));
         c.count = 4'($urandom_range(0, 15));
         c.fill  = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send_cmd(c, st);
      end
      wait_drain();

      // reset pulsed during the second shift of a count=5 command
      c = '{data: 8'h5A, dir: 1'b1, count: 4'd5, fill: 1'b0};
      send_cmd(c, st);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort_mode", 32'(mode), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_done", 32'(done), 32'(0));
      chk("abort_ready", 32'(cmd_ready), 32'(0));
      exp_q.delete();
      fin_q.delete();
      done_cyc_q.delete();
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'(0));
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_idle_done", 32'(done), 32'(0));
      c = '{data: 8'h3C, dir: 1'b0, count: 4'd0, fill: 1'b0};
      send_cmd(c, st);
      wait_drain();
      chk("after_abort_reg", 32'(sr_q), 32'h3C);

`ifdef USR_SHIFT_CTRL_QUEUE_EN
      done_seen.delete();
      c = '{data: 8'h81, dir: 1'b0, count: 4'd1, fill: 1'b0};
      send_cmd(c, st_a);
      c = '{data: 8'h42, dir: 1'b0, count: 4'd2, fill: 1'b1};
      send_cmd(c, st_b);
      c = '{data: 8'h99, dir: 1'b1, count: 4'd1, fill: 1'b0};
      send_cmd(c, st_c);
      wait_drain();
      chk("q_a_stall", 32'(st_a), 32'(0));
      chk("q_b_stall", 32'(st_b), 32'(0));
      chk("q_c_stalled", 32'(st_c > 0), 32'(1));
      chk("q_done_count", 32'(done_seen.size()), 32'(3));
      if (done_seen.size() >= 2)
         chk("q_back_to_back", 32'(done_seen[1] - done_seen[0]), 32'(4));
`else
      st_a = 0;
      st_b = 0;
      st_c = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
